param_seq_detector: RTL and testbench
=====================================

Name: param_seq_detector

Overview:
Parametrised, runtime-programmable serial bit-pattern detector. It is the successor to the fixed single-pattern Moore detector.
- Pattern contents, pattern length (1..MAX_LEN) and overlap mode are loaded through a config port.
- Input is qualified by a valid strobe.
- A saturating match counter is provided.
- Sits on a serial data path; dout feeds downstream control or interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of match counter
RST_PATTERN, 8'b0011_0110, pattern after reset (right-aligned; default detects 110110)
RST_LEN, 6, pattern length after reset
RST_OVERLAP, 1, overlap mode after reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
seq_in  in  1  serial data bit
seq_valid  in  1  seq_in is sampled only when high
cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit cfg_len-1 is the first bit received
cfg_len  in  LEN_W=$clog2(MAX_LEN+1)  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
dout  out  1  one-cycle match pulse (registered)
match_cnt  out  CNT_W  saturating number of matches
cfg_err  out  1  high while the loaded length is invalid (0 or >MAX_LEN)

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high: on clk rising edge with rst=1, all state takes reset values.
  - Reset values: hist=0, fill=0, pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP, dout=0, match_cnt=0, cfg_err=0.
- State:
  - hist: MAX_LEN-bit shift register; newest bit in LSB.
  - fill: bits accepted since the last clear; saturates at MAX_LEN.
- Accepted beat (seq_valid=1, cfg_load=0, cfg_err=0):
  - hist <= {hist[MAX_LEN-2:0], seq_in}.
  - fill <= min(fill+1, MAX_LEN).
  - hit = (fill+1 >= len) AND ({hist,seq_in} low len bits == pattern low len bits).
- Output on hit:
  - dout=1 in the following cycle only: latency 1 clk after the completing beat.
  - match_cnt increments, saturating at 2^CNT_W-1.
  - Overlap=0: fill is cleared to 0 on hit, so the next match needs len fresh bits. Overlap=1: fill continues.
- seq_valid=0: hist, fill and match_cnt hold; dout=0. Gaps of any length are transparent.
- cfg_load (has priority over seq_valid in the same cycle; that beat is dropped):
  - latches pattern/len/overlap;
  - clears hist, fill and match_cnt; dout=0 next cycle;
  - cfg_err <= (cfg_len==0 || cfg_len>MAX_LEN).
- While cfg_err=1: beats are ignored, dout stays 0, counter holds. The error clears only on a valid cfg_load or on rst.
- Reset mid-stream discards partial matches; detection restarts from fill=0.
- Width rule: compare mask = (1<<len)-1, computed in LEN_W+MAX_LEN bits so that len=MAX_LEN does not overflow.
- Control structure is an explicit 2-state FSM:
  - IDLE_ERR (cfg_err=1) -> RUN on a valid load;
  - RUN -> IDLE_ERR on an invalid load;
  - reset -> RUN.

Optional Feature:
Macro SEQ_DET_MATCH_CNT_EN.
- Defined: the match counter is built as described above.
- Undefined: no counter flops are synthesised, and match_cnt is tied to 0. dout, cfg_err and all timing are unchanged.

Decomposition:
- Package seq_det_pkg holds:
  - the fsm state typedef (RUN, IDLE_ERR);
  - the LEN_W helper function;
  - the default pattern/length constants.
- Sub-module seq_det_sat_cnt (parametrised CNT_W; inc, clr, count) holds the saturating counter and is instantiated under SEQ_DET_MATCH_CNT_EN.

Test Plan:
- Reset defaults, overlap=1, stream 1,1,0,1,1,0,1,1,0 all valid -> dout pulses 1 clk after beats 6 and 9; match_cnt=2.
- cfg_load pattern=0b110110, len=6, overlap=0, same stream -> single pulse after beat 6; match_cnt=1.
- Same stream with seq_valid low 3 cycles between beats 4 and 5 -> pulses are delayed by 3 clks, with the same count.
- cfg_load len=9 (MAX_LEN=8) -> cfg_err=1; the stream yields no dout. A following load with len=3, pattern=0b101 and stream 1,0,1,0,1 (overlap=1) -> cfg_err=0 and 2 pulses.
- CNT_W=2, len=1, pattern=1, stream of 5 ones -> 5 dout pulses; match_cnt saturates at 3.
- rst asserted after 5 beats of 110110 and stream resumes with 0 -> no pulse. cfg_load and seq_valid in the same cycle -> that beat is ignored (fill=0).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   state_t      : control FSM states (RUN, IDLE_ERR)
//   len_w()      : width of the pattern-length field for a given MAX_LEN
//   DEF_*        : pattern, length and overlap mode loaded on reset
package seq_det_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        IDLE_ERR = 1'b1
    } state_t;

    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam logic [7:0] DEF_PATTERN = 8'b0011_0110;
    localparam int unsigned DEF_LEN     = 6;
    localparam logic        DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter used for the detector's match count.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   inc   : count one event (ignored once the counter is at all-ones)
//   clr   : synchronous clear
//   count : current count value
module seq_det_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN builds the saturating match
// counter; without it match_cnt is tied to zero.
//   clk, rst     : clock, synchronous active-high reset
//   seq_in       : serial data bit, sampled when seq_valid is high
//   seq_valid    : data qualifier
//   cfg_load     : one-cycle strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  : right-aligned pattern, bit cfg_len-1 received first
//   cfg_len      : pattern length (1..MAX_LEN valid)
//   cfg_overlap  : 1 = overlapping matches allowed
//   dout         : registered one-cycle match pulse
//   match_cnt    : saturating match count
//   cfg_err      : loaded length invalid; detection suspended
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned          RST_LEN     = DEF_LEN,
    parameter logic                 RST_OVERLAP = DEF_OVERLAP,
    localparam int unsigned         LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seq_in,
    input  logic               seq_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam int unsigned MW = LEN_W + MAX_LEN;

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] hist, hist_next;
    logic [LEN_W-1:0]   fill, fill_next;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [LEN_W:0]     fill_p1;
    logic [MW-1:0]      mask;
    logic               accept;
    logic               hit;

    assign cfg_err = (state == IDLE_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = ((cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN))) ? IDLE_ERR : RUN;
        end
    end

    always_comb begin
        accept    = seq_valid && !cfg_load && (state == RUN);
        hist_next = (hist << 1) | MAX_LEN'(seq_in);
        fill_p1   = {1'b0, fill} + (LEN_W + 1)'(1);
        // Mask is built wider than the pattern so len == MAX_LEN cannot overflow.
        mask      = (MW'(1) << len) - MW'(1);
        hit       = accept && (fill_p1 >= {1'b0, len})
                    && ((MW'(hist_next ^ pattern) & mask) == '0);
        fill_next = fill;
        if (hit && !overlap) begin
            fill_next = '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
            fill_next = fill_p1[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= RST_PATTERN;
            len     <= LEN_W'(RST_LEN);
            overlap <= RST_OVERLAP;
            dout    <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= cfg_len;
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            dout    <= 1'b0;
        end else begin
            dout <= hit;
            if (accept) begin
                hist <= hist_next;
                fill <= fill_next;
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (hit),
        .clr  (cfg_load),
        .count(match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, seq_in, seq_valid, cfg_load, cfg_overlap;
    logic [7:0]       cfg_pattern;
    logic [3:0]       cfg_len;
    logic             dout, cfg_err;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of bits received since the last clear.
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ov, m_err, m_dout;
    int         m_cnt;
    logic       m_q[$];

    param_seq_detector #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seq_in     (seq_in),
        .seq_valid  (seq_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .dout       (dout),
        .match_cnt  (match_cnt),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt();
`ifdef SEQ_DET_MATCH_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic void model_clock(input logic r, input logic ld, input logic [7:0] cp,
                                        input logic [3:0] cl, input logic co,
                                        input logic v, input logic b);
        logic match;
        if (r) begin
            m_pat = 8'h36; m_len = 6; m_ov = 1'b1; m_err = 1'b0;
            m_cnt = 0; m_dout = 1'b0; m_q.delete();
        end else if (ld) begin
            m_pat = cp; m_len = int'(cl); m_ov = co;
            m_err = (cl == 0) || (int'(cl) > MAX_LEN);
            m_cnt = 0; m_dout = 1'b0; m_q.delete();
        end else begin
            m_dout = 1'b0;
            if (v && !m_err) begin
                m_q.push_back(b);
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                if (m_q.size() >= m_len) begin
                    match = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (m_q[m_q.size() - 1 - i] != m_pat[i]) match = 1'b0;
                    if (match) begin
                        m_dout = 1'b1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                        if (!m_ov) m_q.delete();
                    end
                end
            end
        end
    endfunction

    task automatic cyc(input logic r, input logic ld, input logic [7:0] cp, input logic [3:0] cl,
                       input logic co, input logic v, input logic b);
        rst = r; cfg_load = ld; cfg_pattern = cp; cfg_len = cl; cfg_overlap = co;
        seq_valid = v; seq_in = b;
        model_clock(r, ld, cp, cl, co, v, b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 8'h00, 4'd0, 0, 0, 0);
        cyc(1, 0, 8'h00, 4'd0, 0, 1, 1);
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dout); end
        checks++;
        if (match_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        cyc(0, 0, 8'h00, 4'd0, 0, 0, 0);
    endtask

    task automatic test_overlap_default();
        logic [8:0] s = 9'b110110110;
        int pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 8'h00, 4'd0, 0, 1, s[8 - i]);
            pulses += int'(dout);
            checks++;
            if (dout !== m_dout || dout !== ((i == 5) || (i == 8))) begin
                errors++; $display("FAIL ovl_dout beat %0d: got %b expected %b", i + 1, dout, m_dout);
            end
        end
        cyc(0, 0, 8'h00, 4'd0, 0, 0, 0);
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL ovl_pulses: got %0d expected 2", pulses); end
        checks++;
        if (int'(match_cnt) != exp_cnt()) begin
            errors++; $display("FAIL ovl_cnt: got %0d expected %0d", match_cnt, exp_cnt());
        end
    endtask

    task automatic test_non_overlap(input int gap);
        logic [8:0] s = 9'b110110110;
        int pulses = 0;
        int cycle = 0;
        int pulse_at = -1;
        cyc(0, 1, 8'b0011_0110, 4'd6, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                for (int g = 0; g < gap; g++) begin
                    cyc(0, 0, 8'h00, 4'd0, 0, 0, s[8 - i]);
                    cycle++;
                    checks++;
                    if (dout !== 1'b0) begin errors++; $display("FAIL gap_dout cycle %0d: got %b expected 0", cycle, dout); end
                end
            end
            cyc(0, 0, 8'h00, 4'd0, 0, 1, s[8 - i]);
            cycle++;
            if (dout === 1'b1) begin pulses++; pulse_at = cycle; end
            checks++;
            if (dout !== m_dout) begin
                errors++; $display("FAIL novl_dout gap %0d beat %0d: got %b expected %b", gap, i + 1, dout, m_dout);
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 6 + gap) begin
            errors++; $display("FAIL novl_pulses gap %0d: got %0d at cycle %0d expected 1 at cycle %0d",
                               gap, pulses, pulse_at, 6 + gap);
        end
        checks++;
        if (int'(match_cnt) != exp_cnt()) begin
            errors++; $display("FAIL novl_cnt: got %0d expected %0d", match_cnt, exp_cnt());
        end
    endtask

    task automatic test_cfg_err();
        logic [4:0] s = 5'b10101;
        int pulses = 0;
        cyc(0, 1, 8'h36, 4'd9, 1, 0, 0);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", cfg_err); end
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 8'h00, 4'd0, 0, 1, $urandom_range(0, 1));
            checks++;
            if (dout !== 1'b0 || cfg_err !== 1'b1) begin
                errors++; $display("FAIL err_quiet beat %0d: got dout %b err %b expected 0 1", i, dout, cfg_err);
            end
        end
        cyc(0, 1, 8'b0000_0101, 4'd3, 1, 0, 0);
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", cfg_err); end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 4'd0, 0, 1, s[4 - i]);
            pulses += int'(dout);
            checks++;
            if (dout !== m_dout) begin errors++; $display("FAIL len3_dout beat %0d: got %b expected %b", i + 1, dout, m_dout); end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL len3_pulses: got %0d expected 2", pulses); end
        cyc(0, 1, 8'h00, 4'd0, 1, 0, 0);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_len0: got %b expected 1", cfg_err); end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        cyc(0, 1, 8'b0000_0001, 4'd1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 4'd0, 0, 1, 1);
            pulses += int'(dout);
            checks++;
            if (dout !== 1'b1) begin errors++; $display("FAIL sat_dout beat %0d: got %b expected 1", i + 1, dout); end
        end
        checks++;
        if (pulses != 5) begin errors++; $display("FAIL sat_pulses: got %0d expected 5", pulses); end
        checks++;
        if (int'(match_cnt) != exp_cnt()) begin
            errors++; $display("FAIL sat_cnt: got %0d expected %0d", match_cnt, exp_cnt());
        end
    endtask

    task automatic test_reset_mid_and_priority();
        logic [4:0] s = 5'b11011;
        cyc(0, 1, 8'b0011_0110, 4'd6, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 4'd0, 0, 1, s[4 - i]);
        cyc(1, 0, 8'h00, 4'd0, 0, 0, 0);
        cyc(0, 0, 8'h00, 4'd0, 0, 1, 0);
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL rst_mid_dout: got %b expected 0", dout); end
        // Load with a valid beat in the same cycle: that beat must not count.
        cyc(0, 1, 8'b0000_0011, 4'd2, 1, 1, 1);
        cyc(0, 0, 8'h00, 4'd0, 0, 1, 1);
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL load_prio_dout: got %b expected 0", dout); end
        cyc(0, 0, 8'h00, 4'd0, 0, 1, 1);
        checks++;
        if (dout !== 1'b1) begin errors++; $display("FAIL load_prio_next: got %b expected 1", dout); end
    endtask

    task automatic test_random();
        logic r, ld, co, v, b;
        logic [7:0] cp;
        logic [3:0] cl;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 59) == 0);
            cp = 8'($urandom);
            cl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            co = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            cyc(r, ld, cp, cl, co, v, b);
            checks++;
            if (dout !== m_dout || cfg_err !== m_err || int'(match_cnt) != exp_cnt()) begin
                errors++;
                $display("FAIL rand cycle %0d: got dout %b err %b cnt %0d expected %b %b %0d",
                         n, dout, cfg_err, match_cnt, m_dout, m_err, exp_cnt());
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap_default();
        test_non_overlap(0);
        test_non_overlap(3);
        test_cfg_err();
        test_saturate();
        test_reset_mid_and_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
